// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter/sequencer sharing one single-ported memory
// between the instruction-fetch port and the load/store data port.
module mem_port_arbiter #(
    parameter int READ_LAT = 1,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_rw,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in_bits,
    input  logic [DATA_W-1:0] mem_out_bits,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              req_any;
    logic              sel_data;
    logic              misal;
    logic [DATA_W-1:0] sel_addr;

    // port id 1 = data port; on a tie the port not granted last wins
    always_comb begin
        req_any  = i_req | d_req;
        sel_data = d_req & (~i_req | ~last_q);
        sel_addr = sel_data ? d_addr : i_addr;
        misal    = |sel_addr[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    port_d  = sel_data;
                    last_d  = sel_data;
                    addr_d  = sel_addr;
                    wdata_d = sel_data ? d_wdata : wdata_q;
                    err_d   = misal;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = misal ? RESP : (sel_data & d_we) ? WRITE : READ;
                end
            end
            READ: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    rdata_d = mem_out_bits;
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rw      = state_q == READ;
        mem_wr      = state_q == WRITE;
        busy        = state_q != IDLE;
        mem_addr    = addr_q;
        mem_in_bits = wdata_q;
        i_ack       = (state_q == RESP) & ~port_q;
        d_ack       = (state_q == RESP) & port_q;
        i_err       = i_ack & err_q;
        d_err       = d_ack & err_q;
        i_rdata     = i_ack ? rdata_q : '0;
        d_rdata     = d_ack ? rdata_q : '0;
    end
endmodule
